nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead adder cell, one nibble per cycle, LSB nibble first.
- Sits between an operand producer and a result consumer, using valid/ready on both sides.
- Trades latency for area on wide ALU operations.

---
 rtl/alu_pkg.sv | 13 +
 rtl/nibble_serial_adder_ctrl_cla.sv | 27 ++
 rtl/nibble_serial_adder_ctrl.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package alu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;

  localparam int NIBBLE_W = 4;

  // Number of 4-bit slices needed to cover an operand of the given width.
  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_cla.sv
// 4-bit carry-lookahead adder cell shared by the serial sequencer.
module _4bit_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c[0]  = c_in;
    c[1]  = g[0] | (p[0] & c_in);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c_in);
    s     = p ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract performed one nibble per cycle through a single
// 4-bit CLA cell, with valid/ready handshakes on the request and result sides.
module nibble_serial_adder_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 8");
  end

  nsa_state_t state;
  nsa_state_t state_next;

  logic [WIDTH-1:0]    a_reg;
  logic [WIDTH-1:0]    b_reg;      // B, already inverted for subtract
  logic                carry;      // seeded with sub so subtract gets its +1
  logic [IDX_W-1:0]    idx;
  logic                last;
  logic [NIBBLE_W-1:0] cell_s;
  logic                cell_c;

  assign last = (idx == IDX_W'(NIB - 1));

  _4bit_cla u_cla (
    .a     (a_reg[NIBBLE_W*idx +: NIBBLE_W]),
    .b     (b_reg[NIBBLE_W*idx +: NIBBLE_W]),
    .c_in  (carry),
    .s     (cell_s),
    .c_out (cell_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; DONE never accepts, even on its hand-off cycle.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-nibble result accumulation and final flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[NIBBLE_W*idx +: NIBBLE_W] <= cell_s;
          carry <= cell_c;
          if (last) begin
            c_out <= cell_c;
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (cell_s[NIBBLE_W-1] != a_reg[WIDTH-1]);
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a cycle-level reference model.
module tb_nibble_serial_adder_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_vec = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 computing, 2 result presented.
  int           m_phase = 0;
  int           m_left  = 0;
  bit           m_live  = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_c     = 1'b0;
  logic         m_o     = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_c;
  logic         p_o;

  always @(posedge clk) begin
    logic [W:0]   full;
    logic [W-1:0] bp;
    m_live = 1'b1;
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_c     = 1'b0;
      m_o     = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          bp    = sub ? ~b : b;
          full  = {1'b0, a} + {1'b0, bp} + (W+1)'(sub);
          p_sum = full[W-1:0];
          p_c   = full[W];
          p_o   = (a[W-1] == bp[W-1]) && (p_sum[W-1] != a[W-1]);
          m_left  = NIB;
          m_phase = 1;
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_sum   = p_sum;
            m_c     = p_c;
            m_o     = p_o;
            m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model; sum is partial while computing.
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready", 32'(in_ready), 32'(m_phase == 0));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      if (m_phase != 1) begin
        check("sum", 32'(sum), 32'(m_sum));
        check("c_out", 32'(c_out), 32'(m_c));
        check("ovf", 32'(ovf), 32'(m_o));
      end
    end
  end

  task automatic wait_result(output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!out_valid) check("timeout_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb; sub = ts;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(cnt);
    check({name, "_latency"}, 32'(cnt), 32'(NIB));
    check({name, "_sum"}, 32'(sum), 32'(es));
    check({name, "_c_out"}, 32'(c_out), 32'(ec));
    check({name, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;

    run_op("add", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("borrow", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

    // Backpressure: result held while a second request waits.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h00FF; b = 16'h0F01; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(cnt);
    in_valid = 1'b1;
    a = 16'h0010; b = 16'h0020; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum", 32'(sum), 32'h1000);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("handoff_in_ready", 32'(in_ready), 32'd1);
    check("handoff_out_valid", 32'(out_valid), 32'd0);
    check("handoff_sum", 32'(sum), 32'h1000);
    @(negedge clk);
    in_valid = 1'b0;
    wait_result(cnt);
    check("bp2_latency", 32'(cnt), 32'(NIB));
    check("bp2_sum", 32'(sum), 32'h0030);
    @(negedge clk);

    // Reset while the third nibble is being processed.
    in_valid = 1'b1;
    a = 16'hAAAA; b = 16'h1111; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    run_op("after_abort", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
